// File: rtl/ex_weights_mem_bank.sv
// rtl/ex_weights_mem_bank.sv - banked weight memory with row-burst reader and 2-entry output FIFO
module ex_weights_mem_bank #(
    parameter int BITSIZE = 14,
    parameter int LANES   = 4,
    parameter int ROWS    = 256,
    localparam int AW     = $clog2(ROWS*LANES),
    localparam int RW     = $clog2(ROWS)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr,
    input  logic [AW-1:0]              wr_index,
    input  logic signed [BITSIZE-1:0]  data_in,
    input  logic                       rd_start,
    input  logic [RW-1:0]              rd_row,
    input  logic [RW:0]                rd_len,
    input  logic                       out_ready,
    output logic                       out_valid,
    output logic [LANES*BITSIZE-1:0]   data_out,
    output logic                       busy,
    output logic                       done,
    output logic                       err
);
    localparam int LB = $clog2(LANES);
    localparam int DW = LANES*BITSIZE;

    typedef enum logic [1:0] {IDLE, BURST, DRAIN} state_t;

    state_t          state;
    logic [RW-1:0]   cur_row;
    logic [RW:0]     rows_left;
    logic [1:0]      count;
    logic            inflight;
    logic            wptr;
    logic            rptr;
    logic [DW-1:0]   fifo [2];
    logic [DW-1:0]   ram_q;

    logic            pop;
    logic            issue;
    logic            last_beat;
    logic            start_ok;
    logic            push;
    logic [1:0]      occ;
    logic [1:0]      occ_after;
    logic [LB-1:0]   wr_bank;
    logic [RW-1:0]   wr_row;
    logic [RW-1:0]   next_row;

    assign wr_bank   = wr_index[LB-1:0];
    assign wr_row    = wr_index[AW-1:LB];

    // The registered read result counts as an occupied slot until it is popped or pushed.
    assign out_valid = (count != 2'd0) || inflight;
    assign pop       = out_valid && out_ready;
    assign occ       = count + {1'b0, inflight};
    assign occ_after = occ - {1'b0, pop};
    assign issue     = (state == BURST) && (occ_after < 2'd2);
    assign last_beat = (state == DRAIN) && pop && (occ == 2'd1);
    assign done      = last_beat;
    assign busy      = (state != IDLE);
    assign start_ok  = rd_start && (rd_len != '0) && ((state == IDLE) || last_beat);
    assign push      = inflight && !((count == 2'd0) && pop);
    assign next_row  = (cur_row == RW'(ROWS-1)) ? '0 : cur_row + 1'b1;

    always_comb begin
        data_out = '0;
        if (count != 2'd0) begin
            data_out = fifo[rptr];
        end else if (inflight) begin
            data_out = ram_q;
        end
    end

    for (genvar k = 0; k < LANES; k++) begin : g_bank
        logic [BITSIZE-1:0] mem [ROWS];
        logic [BITSIZE-1:0] rd_q;

        // Read and write share one block so a same-address collision returns the old word.
        always_ff @(posedge clk) begin
            if (wr && (wr_bank == LB'(k)) && (int'(wr_row) < ROWS)) begin
                mem[wr_row] <= data_in;
            end
            if (issue) begin
                rd_q <= mem[cur_row];
            end
        end

        assign ram_q[k*BITSIZE +: BITSIZE] = rd_q;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo[wptr] <= ram_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cur_row   <= '0;
            rows_left <= '0;
            count     <= 2'd0;
            inflight  <= 1'b0;
            wptr      <= 1'b0;
            rptr      <= 1'b0;
            err       <= 1'b0;
        end else begin
            inflight <= issue;
            count    <= count + {1'b0, push} - {1'b0, pop && (count != 2'd0)};
            if (push) begin
                wptr <= ~wptr;
            end
            if (pop && (count != 2'd0)) begin
                rptr <= ~rptr;
            end

            case (state)
                IDLE: begin
                    if (start_ok) begin
                        state     <= BURST;
                        cur_row   <= rd_row;
                        rows_left <= rd_len;
                    end
                end
                BURST: begin
                    if (rd_start) begin
                        err <= 1'b1;
                    end
                    if (issue) begin
                        cur_row   <= next_row;
                        rows_left <= rows_left - 1'b1;
                        if (rows_left == (RW+1)'(1)) begin
                            state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    // A new burst may start in the same cycle the final beat leaves.
                    if (last_beat) begin
                        if (start_ok) begin
                            state     <= BURST;
                            cur_row   <= rd_row;
                            rows_left <= rd_len;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (rd_start) begin
                        err <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/ex_weights_mem_bank.md
EX_WEIGHTS_MEM_BANK -- requirements
Module: ex_weights_mem_bank

Interface
REQ-001 SHALL have parameter BITSIZE, default 14, the signed weight width in bits.
REQ-002 SHALL have parameter LANES, default 4, the number of banks and the number of words per output beat.
REQ-003 SHALL have parameter ROWS, default 256, the rows per bank; total capacity is ROWS*LANES words.
REQ-004 SHALL have parameters AW = clog2(ROWS*LANES) and RW = clog2(ROWS), both derived and not user-set.
REQ-005 SHALL have clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have rst, input, 1, the reset: asynchronous and active-low.
REQ-007 SHALL have wr, input, 1, the word write strobe.
REQ-008 SHALL have wr_index, input, AW, the write word address.
REQ-009 SHALL have data_in, input, BITSIZE, signed write data.
REQ-010 SHALL have rd_start, input, 1, a single-cycle pulse that starts a burst.
REQ-011 SHALL have rd_row, input, RW, the first row of the burst.
REQ-012 SHALL have rd_len, input, RW+1, the burst length in rows.
REQ-013 SHALL have out_ready, input, 1, the consumer ready signal.
REQ-014 SHALL have out_valid, output, 1, indicating data_out holds a beat.
REQ-015 SHALL have data_out, output, LANES*BITSIZE, one row; lane k sits in bits [k*BITSIZE +: BITSIZE].
REQ-016 SHALL have busy, output, 1, high while a burst is active.
REQ-017 SHALL have done, output, 1, a one-cycle pulse on the last beat accepted.
REQ-018 SHALL have err, output, 1, a sticky flag for a rejected rd_start.

Function
REQ-019 SHALL store word address w in bank (w mod LANES), row (w div LANES); LANES SHALL be a power of two.
REQ-020 SHALL write one word in the cycle wr is high, in any state, independent of reads.
REQ-021 SHALL use FSM states IDLE, BURST, DRAIN.
- IDLE->BURST on rd_start with rd_len!=0.
- BURST->DRAIN when the last row read is issued.
- DRAIN->IDLE when the last beat is accepted.
REQ-022 SHALL read all LANES banks at the same row per issue, with 1-cycle latency from issue to data being buffered.
REQ-023 SHALL have a 2-entry output FIFO. A read issues only when buffered plus in-flight entries < 2 after counting this cycle's pop.
REQ-024 SHALL transfer a beat when out_valid && out_ready. data_out and out_valid SHALL hold stable while out_valid && !out_ready.
REQ-025 SHALL sustain one beat per cycle when out_ready is held high; the first beat SHALL appear 2 cycles after rd_start.
REQ-026 SHALL increment the row address modulo ROWS, so a burst wraps from row ROWS-1 to row 0.
REQ-027 SHALL ignore rd_start with rd_len==0: no beats, busy stays low, done is not pulsed.
REQ-028 SHALL ignore rd_start while busy, set err, and leave the current burst unaffected. err SHALL clear only on reset.
REQ-029 SHALL return pre-write data when a write and a read of the same bank and row occur in the same cycle (read-first); the write still commits.
REQ-030 SHALL assert busy from the cycle after an accepted rd_start until the cycle after done.
REQ-031 SHALL permit rd_start in the cycle done is high, with no bubble beyond the read latency.

Reset
REQ-032 SHALL, while rst is low: set the FSM to IDLE, empty the FIFO, clear in-flight reads, and drive out_valid, busy, done and err to 0 and data_out to 0.
REQ-033 SHALL NOT clear memory contents on reset; memory SHALL be inferable as block RAM.
REQ-034 SHALL abort a burst on reset mid-operation; no beat of it appears after reset is released.

Verification
REQ-035 Write words 0..15 with value = index, LANES=4. Then rd_start, rd_row=1, rd_len=2, out_ready=1 -> beats {7,6,5,4} then {11,10,9,8} (lane3..lane0) on consecutive cycles; done on beat 2.
REQ-036 Same burst with out_ready low for 5 cycles after the first valid -> beat 1 held stable, no loss or duplication, 2 beats total.
REQ-037 ROWS=256, rd_row=255, rd_len=2 -> row 255 then row 0 returned.
REQ-038 rd_start during a burst -> err=1, original beat count unchanged; rd_len=0 -> no out_valid and busy stays 0.
REQ-039 Write word 4 = -3 in the same cycle row 1 is issued -> the beat shows the old value; a re-read shows -3.
REQ-040 Assert rst low mid-burst -> out_valid, busy and err are 0 immediately; memory retains its data on the next read.
